// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample prescaler, per-channel 2-flop synchronizer,
// stability counter and rise/fall pulses. Define DEBOUNCE_GLITCH_CNT_EN for glitch counters.
module debounce_multi #(
    parameter int                NUM_CH       = 4,
    parameter int                MAX_COUNT    = 660,
    parameter int                STABLE_TICKS = 2,
    parameter logic [NUM_CH-1:0] RST_VAL      = {NUM_CH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  deb_en,
    input  logic [NUM_CH-1:0]     in_put,
    output logic [NUM_CH-1:0]     out_put,
    output logic [NUM_CH-1:0]     rise,
    output logic [NUM_CH-1:0]     fall,
    output logic                  tick,
    input  logic                  glitch_clr,
    output logic [8*NUM_CH-1:0]   glitch_cnt
);

    localparam int PW = $clog2(MAX_COUNT);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] CNT_LAST  = PW'(MAX_COUNT - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_TICKS - 1);

    logic [PW-1:0]              presc_q, presc_d;
    logic                       tick_q, tick_d;
    logic [NUM_CH-1:0]          sync1_q, sync1_d;
    logic [NUM_CH-1:0]          sync2_q, sync2_d;
    logic [NUM_CH-1:0]          out_q, out_d;
    logic [NUM_CH-1:0]          rise_q, rise_d;
    logic [NUM_CH-1:0]          fall_q, fall_d;
    logic [NUM_CH-1:0][CW-1:0]  stab_q, stab_d;
    logic [NUM_CH-1:0]          glitch;

    always_comb begin
        presc_d = '0;
        tick_d  = 1'b0;
        if (deb_en) begin
            tick_d  = (presc_q == CNT_LAST);
            presc_d = (presc_q == CNT_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        sync1_d = in_put;
        sync2_d = sync1_q;
    end

    // Channels only advance on the registered tick, so deb_en low freezes them.
    always_comb begin
        out_d  = out_q;
        stab_d = stab_q;
        rise_d = '0;
        fall_d = '0;
        glitch = '0;
        if (tick_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2_q[i] == out_q[i]) begin
                    stab_d[i] = '0;
                    glitch[i] = (stab_q[i] != '0);
                end else if (stab_q[i] == STAB_LAST) begin
                    out_d[i]  = sync2_q[i];
                    stab_d[i] = '0;
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            out_q   <= RST_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            stab_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stab_q  <= stab_d;
        end
    end

    assign out_put = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign tick    = tick_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [NUM_CH-1:0][7:0] gcnt_q, gcnt_d;

    // Clear wins over a same-cycle glitch; counts saturate at 255.
    always_comb begin
        gcnt_d = gcnt_q;
        if (glitch_clr) begin
            gcnt_d = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (glitch[i] && (gcnt_q[i] != 8'hFF)) begin
                    gcnt_d[i] = gcnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt = gcnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = ^{glitch_clr, glitch};
    assign glitch_cnt    = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (NUM_CH=2, MAX_COUNT=4, STABLE_TICKS=3).
module tb_debounce_multi;

    logic        clk;
    logic        rst;
    logic        deb_en;
    logic [1:0]  in_put;
    logic [1:0]  out_put;
    logic [1:0]  rise;
    logic [1:0]  fall;
    logic        tick;
    logic        glitch_clr;
    logic [15:0] glitch_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [1:0] rise_seen;
    logic       tick_seen;

    debounce_multi #(
        .NUM_CH       (2),
        .MAX_COUNT    (4),
        .STABLE_TICKS (3),
        .RST_VAL      (2'b00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .deb_en     (deb_en),
        .in_put     (in_put),
        .out_put    (out_put),
        .rise       (rise),
        .fall       (fall),
        .tick       (tick),
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] value, input logic enable);
        in_put = value;
        deb_en = enable;
    endtask

    // cyc counts rising edges since the last reset release; samples land on the falling edge
    task automatic stepTo(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        glitch_clr = 1'b0;
        applyStimulus(2'b11, 1'b1);
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_out",    {30'd0, out_put}, 32'h0);
        checkOutput("rst_rise",   {30'd0, rise},    32'h0);
        checkOutput("rst_fall",   {30'd0, fall},    32'h0);
        checkOutput("rst_tick",   {31'd0, tick},    32'h0);
        checkOutput("rst_glitch", {16'd0, glitch_cnt}, 32'h0);

        applyStimulus(2'b00, 1'b1);
        rst = 1'b0;
        cyc = 0;
        stepTo(3);
        checkOutput("tick_before_first", {31'd0, tick}, 32'h0);
        stepTo(4);
        checkOutput("tick_first", {31'd0, tick}, 32'h1);
        stepTo(5);
        checkOutput("tick_one_clk", {31'd0, tick}, 32'h0);

        $display("[TB] clean rising edge on channel 0");
        applyStimulus(2'b01, 1'b1);
        stepTo(16);
        checkOutput("clean_not_yet", {30'd0, out_put}, 32'h0);
        stepTo(17);
        checkOutput("clean_out",  {30'd0, out_put}, 32'h1);
        checkOutput("clean_rise", {30'd0, rise},    32'h1);
        checkOutput("clean_fall", {30'd0, fall},    32'h0);
        stepTo(18);
        checkOutput("clean_rise_end", {30'd0, rise}, 32'h0);

        $display("[TB] glitch on channel 1");
        applyStimulus(2'b11, 1'b1);
        rise_seen = 2'b00;
        while (cyc < 30) begin
            stepTo(cyc + 1);
            rise_seen = rise_seen | rise;
            if (cyc == 26) applyStimulus(2'b01, 1'b1);
            if (cyc == 29) begin
`ifdef DEBOUNCE_GLITCH_CNT_EN
                checkOutput("glitch_cnt_inc", {16'd0, glitch_cnt}, 32'h0100);
`else
                checkOutput("glitch_cnt_tied", {16'd0, glitch_cnt}, 32'h0);
`endif
            end
        end
        checkOutput("glitch_out",  {30'd0, out_put},   32'h1);
        checkOutput("glitch_rise", {30'd0, rise_seen}, 32'h0);
        glitch_clr = 1'b1;
        stepTo(31);
        glitch_clr = 1'b0;
        checkOutput("glitch_clr", {16'd0, glitch_cnt}, 32'h0);

        $display("[TB] simultaneous transitions");
        applyStimulus(2'b10, 1'b1);
        stepTo(44);
        checkOutput("simul_not_yet", {30'd0, out_put}, 32'h1);
        checkOutput("simul_no_pulse", {28'd0, rise, fall}, 32'h0);
        stepTo(45);
        checkOutput("simul_out",  {30'd0, out_put}, 32'h2);
        checkOutput("simul_rise", {30'd0, rise},    32'h2);
        checkOutput("simul_fall", {30'd0, fall},    32'h1);
        stepTo(46);
        checkOutput("simul_pulse_end", {28'd0, rise, fall}, 32'h0);

        $display("[TB] enable gating");
        applyStimulus(2'b11, 1'b1);
        stepTo(49);
        applyStimulus(2'b11, 1'b0);
        tick_seen = 1'b0;
        while (cyc < 89) begin
            stepTo(cyc + 1);
            tick_seen = tick_seen | tick;
        end
        checkOutput("gate_no_tick", {31'd0, tick_seen}, 32'h0);
        checkOutput("gate_hold",    {30'd0, out_put},   32'h2);
        applyStimulus(2'b11, 1'b1);
        stepTo(92);
        checkOutput("reen_tick_wait", {31'd0, tick}, 32'h0);
        stepTo(93);
        checkOutput("reen_tick", {31'd0, tick}, 32'h1);
        stepTo(97);
        checkOutput("reen_not_yet", {30'd0, out_put}, 32'h2);
        stepTo(98);
        checkOutput("reen_out",  {30'd0, out_put}, 32'h3);
        checkOutput("reen_rise", {30'd0, rise},    32'h1);

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(2'b01, 1'b1);
        stepTo(107);
        rst = 1'b1;
        #1;
        checkOutput("arst_out",   {30'd0, out_put}, 32'h0);
        checkOutput("arst_pulse", {28'd0, rise, fall}, 32'h0);
        checkOutput("arst_tick",  {31'd0, tick}, 32'h0);
        stepTo(109);
        checkOutput("arst_glitch", {16'd0, glitch_cnt}, 32'h0);
        rst = 1'b0;
        cyc = 0;
        stepTo(1);
        checkOutput("arst_exit_pulse", {28'd0, rise, fall}, 32'h0);
        stepTo(12);
        checkOutput("arst_full_wait", {30'd0, out_put}, 32'h0);
        stepTo(13);
        checkOutput("arst_out_after", {30'd0, out_put}, 32'h1);
        checkOutput("arst_rise_after", {30'd0, rise},   32'h1);
        checkOutput("arst_fall_after", {30'd0, fall},   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
